// File: rtl/gen_if_pkg.sv
// Shared constants and the increment transform for gen_if_pipe.
// The transform works on a fixed wide word; callers pass their real width.
package gen_if_pkg;

    localparam int MODE_PASS   = 0;
    localparam int MODE_INC    = 1;
    localparam int MODE_SAT    = 2;
    localparam int DEPTH_MAX   = 8;
    localparam int XFORM_W_MAX = 64;

    typedef logic [XFORM_W_MAX-1:0] xdata_t;

    // Returns {ovf, data}; only the low w bits of data are meaningful.
    function automatic logic [XFORM_W_MAX:0] inc_xform(
        input xdata_t data,
        input int     mode,
        input int     w
    );
        xdata_t               mask;
        xdata_t               d;
        logic                 all_ones;
        logic [XFORM_W_MAX:0] res;
        mask     = (w >= XFORM_W_MAX) ? '1 : ((xdata_t'(1) << w) - xdata_t'(1));
        d        = data & mask;
        all_ones = (d == mask);
        res      = {1'b0, d};
        case (mode)
            MODE_INC: res = {all_ones, (d + xdata_t'(1)) & mask};
            MODE_SAT: res = {all_ones, all_ones ? d : (d + xdata_t'(1))};
            default:  res = {1'b0, d};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/gen_if_pipe_if.sv
// Valid/ready handshake bundle for gen_if_pipe: producer side in_*, consumer side out_*.
// master = surrounding logic, slave = the pipe itself.
interface gen_if_pipe_if #(
    parameter int W = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/gen_if_slice.sv
// One pipeline register slice {valid, data, ovf} with a pass-through ready chain.
// Data only loads when the upstream word is valid, so bubbles never clobber it.
module gen_if_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    input  logic         up_ovf,
    input  logic         dn_ready,
    output logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         ovf
);

    logic         valid_reg;
    logic [W-1:0] data_reg;
    logic         ovf_reg;

    assign ready = !valid_reg || dn_ready;
    assign valid = valid_reg;
    assign data  = data_reg;
    assign ovf   = ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            ovf_reg   <= 1'b0;
        end else if (ready) begin
            valid_reg <= up_valid;
            if (up_valid) begin
                data_reg <= up_data;
                ovf_reg  <= up_ovf;
            end
        end
    end

endmodule

// File: rtl/gen_if_pipe.sv
// Optional increment stage with DEPTH register slices (0 = combinational bypass).
// Define GEN_IF_PIPE_STATS_EN to add saturating xfer_cnt/stall_cnt counters.
module gen_if_pipe
    import gen_if_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 1,
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    gen_if_pipe_if.slave     bus,
    output logic             busy
`ifdef GEN_IF_PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if (W >= 1 && W <= XFORM_W_MAX && DEPTH >= 0 && DEPTH <= DEPTH_MAX &&
        MODE >= MODE_PASS && MODE <= MODE_SAT && CNT_W >= 1) begin : g_ok

        // Only bits [W-1:0] and the top ovf bit of the wide result are used.
        logic [XFORM_W_MAX:0] xf_wide_unused;
        logic [W-1:0]         xf_data;
        logic                 xf_ovf;

        assign xf_wide_unused = inc_xform(xdata_t'(bus.in_data), MODE, W);
        assign xf_data        = xf_wide_unused[W-1:0];
        assign xf_ovf         = xf_wide_unused[XFORM_W_MAX];

        if (DEPTH == 0) begin : g_bypass
            logic bypass_unused;
            assign bypass_unused = clk ^ rst_n;
            assign bus.out_valid = bus.in_valid;
            assign bus.in_ready  = bus.out_ready;
            assign bus.out_data  = xf_data;
            assign bus.out_ovf   = xf_ovf;
            assign busy          = 1'b0;
        end else begin : g_chain
            // Index i feeds slice i; index DEPTH is the pipe output.
            logic [DEPTH:0] v_chain;
            logic [DEPTH:0] o_chain;
            logic [DEPTH:0] r_chain;
            logic [W-1:0]   d_chain [DEPTH+1];

            assign v_chain[0]     = bus.in_valid;
            assign d_chain[0]     = xf_data;
            assign o_chain[0]     = xf_ovf;
            assign r_chain[DEPTH] = bus.out_ready;

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slice
                gen_if_slice #(.W(W)) u_slice (
                    .clk      (clk),
                    .rst_n    (rst_n),
                    .up_valid (v_chain[gi]),
                    .up_data  (d_chain[gi]),
                    .up_ovf   (o_chain[gi]),
                    .dn_ready (r_chain[gi+1]),
                    .ready    (r_chain[gi]),
                    .valid    (v_chain[gi+1]),
                    .data     (d_chain[gi+1]),
                    .ovf      (o_chain[gi+1])
                );
            end

            assign bus.in_ready  = r_chain[0];
            assign bus.out_valid = v_chain[DEPTH];
            assign bus.out_data  = d_chain[DEPTH];
            assign bus.out_ovf   = o_chain[DEPTH];
            assign busy          = |v_chain[DEPTH:1];
        end

    end else begin : g_bad
        $error("gen_if_pipe: illegal parameters W=%0d DEPTH=%0d MODE=%0d CNT_W=%0d",
               W, DEPTH, MODE, CNT_W);
        assign bus.in_ready  = 1'b0;
        assign bus.out_valid = 1'b0;
        assign bus.out_data  = '0;
        assign bus.out_ovf   = 1'b0;
        assign busy          = 1'b0;
    end

`ifdef GEN_IF_PIPE_STATS_EN
    logic [CNT_W-1:0] xfer_cnt_reg;
    logic [CNT_W-1:0] xfer_cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    always_comb begin
        xfer_cnt_next  = xfer_cnt_reg;
        stall_cnt_next = stall_cnt_reg;
        if (bus.in_valid && bus.in_ready && !(&xfer_cnt_reg))
            xfer_cnt_next = xfer_cnt_reg + CNT_W'(1);
        if (bus.out_valid && !bus.out_ready && !(&stall_cnt_reg))
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
        end else begin
            xfer_cnt_reg  <= xfer_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign xfer_cnt  = xfer_cnt_reg;
    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_gen_if_pipe.sv
// Directed bench for gen_if_pipe: wrap, saturate, backpressure, bypass, mid-stream reset
// and (with GEN_IF_PIPE_STATS_EN) the saturating statistics counters.
module tb_gen_if_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    logic done        = 1'b0;

    always #5 clk = ~clk;

    gen_if_pipe_if #(.W(8)) bw ();
    gen_if_pipe_if #(.W(8)) bs ();
    gen_if_pipe_if #(.W(8)) bb ();
    gen_if_pipe_if #(.W(8)) bz ();

    logic busy_w, busy_s, busy_b, busy_z;
`ifdef GEN_IF_PIPE_STATS_EN
    logic [3:0] xc [4];
    logic [3:0] sc [4];
`endif

    gen_if_pipe #(.W(8), .DEPTH(3), .MODE(1), .CNT_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(bw), .busy(busy_w)
`ifdef GEN_IF_PIPE_STATS_EN
        , .xfer_cnt(xc[0]), .stall_cnt(sc[0])
`endif
    );

    gen_if_pipe #(.W(8), .DEPTH(3), .MODE(2), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(bs), .busy(busy_s)
`ifdef GEN_IF_PIPE_STATS_EN
        , .xfer_cnt(xc[1]), .stall_cnt(sc[1])
`endif
    );

    gen_if_pipe #(.W(8), .DEPTH(2), .MODE(0), .CNT_W(4)) u_bp (
        .clk(clk), .rst_n(rst_n), .bus(bb), .busy(busy_b)
`ifdef GEN_IF_PIPE_STATS_EN
        , .xfer_cnt(xc[2]), .stall_cnt(sc[2])
`endif
    );

    gen_if_pipe #(.W(8), .DEPTH(0), .MODE(0), .CNT_W(4)) u_byp (
        .clk(clk), .rst_n(rst_n), .bus(bz), .busy(busy_z)
`ifdef GEN_IF_PIPE_STATS_EN
        , .xfer_cnt(xc[3]), .stall_cnt(sc[3])
`endif
    );

    // One line per word leaving the backpressure instance.
    always @(posedge clk)
        if (rst_n && bb.out_valid && bb.out_ready)
            $display("bp out data=%02h", bb.out_data);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        if (!done) begin
            $error("FAIL timeout: directed sequence did not complete");
            $finish;
        end
    end

    initial begin
        bw.in_valid = 0; bw.in_data = 0; bw.out_ready = 1;
        bs.in_valid = 0; bs.in_data = 0; bs.out_ready = 1;
        bb.in_valid = 0; bb.in_data = 0; bb.out_ready = 1;
        bz.in_valid = 0; bz.in_data = 0; bz.out_ready = 1;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", bw.out_valid, 1'b0);
        chk("rst_out_data",  bw.out_data,  8'h00);
        chk("rst_out_ovf",   bw.out_ovf,   1'b0);
        chk("rst_busy",      busy_w,       1'b0);
        chk("rst_in_ready",  bw.in_ready,  1'b1);
        chk("rst_bp_ready",  bb.in_ready,  1'b1);
        rst_n = 1;
        tick();

        // Wrap (MODE 1) and saturate (MODE 2), DEPTH 3, in parallel
        bw.in_valid = 1; bw.in_data = 8'hFF;
        bs.in_valid = 1; bs.in_data = 8'hFF;
        tick();
        chk("lat_c1_valid", bw.out_valid, 1'b0);
        chk("lat_c1_busy",  busy_w,       1'b1);
        bw.in_data = 8'h41;
        bs.in_data = 8'hFE;
        tick();
        chk("lat_c2_valid", bw.out_valid, 1'b0);
        bw.in_valid = 0;
        bs.in_valid = 0;
        tick();
        chk("wrap_ff_valid", bw.out_valid, 1'b1);
        chk("wrap_ff_data",  bw.out_data,  8'h00);
        chk("wrap_ff_ovf",   bw.out_ovf,   1'b1);
        chk("sat_ff_data",   bs.out_data,  8'hFF);
        chk("sat_ff_ovf",    bs.out_ovf,   1'b1);
        tick();
        chk("wrap_41_valid", bw.out_valid, 1'b1);
        chk("wrap_41_data",  bw.out_data,  8'h42);
        chk("wrap_41_ovf",   bw.out_ovf,   1'b0);
        chk("sat_fe_data",   bs.out_data,  8'hFF);
        chk("sat_fe_ovf",    bs.out_ovf,   1'b0);
        tick();
        chk("wrap_drain_valid", bw.out_valid, 1'b0);
        chk("wrap_drain_busy",  busy_w,       1'b0);

        // Reset mid-stream
        bw.in_valid = 1; bw.in_data = 8'h01; tick();
        bw.in_data = 8'h02; tick();
        bw.in_data = 8'h03; tick();
        chk("mid_pre_valid", bw.out_valid, 1'b1);
        chk("mid_pre_data",  bw.out_data,  8'h02);
        rst_n = 0; bw.in_valid = 0;
        #1;
        chk("mid_rst_valid", bw.out_valid, 1'b0);
        chk("mid_rst_busy",  busy_w,       1'b0);
        chk("mid_rst_ready", bw.in_ready,  1'b1);
        chk("mid_rst_data",  bw.out_data,  8'h00);
        tick();
        rst_n = 1;
        tick(); tick(); tick();
        chk("mid_post_valid", bw.out_valid, 1'b0);
        chk("mid_post_busy",  busy_w,       1'b0);
        bw.in_valid = 1; bw.in_data = 8'h20; tick();
        bw.in_valid = 0; tick(); tick();
        chk("mid_new_valid", bw.out_valid, 1'b1);
        chk("mid_new_data",  bw.out_data,  8'h21);
        tick();
        chk("mid_new_gone", bw.out_valid, 1'b0);

        // Backpressure, DEPTH 2
        bb.out_ready = 0;
        bb.in_valid = 1; bb.in_data = 8'h10;
        #1;
        chk("bp_ready_0", bb.in_ready, 1'b1);
        tick();
        bb.in_data = 8'h11;
        #1;
        chk("bp_ready_1", bb.in_ready, 1'b1);
        tick();
        bb.in_data = 8'h12;
        #1;
        chk("bp_full_ready", bb.in_ready,  1'b0);
        chk("bp_full_valid", bb.out_valid, 1'b1);
        chk("bp_full_data",  bb.out_data,  8'h10);
        tick();
        chk("bp_hold_ready", bb.in_ready, 1'b0);
        chk("bp_hold_data",  bb.out_data, 8'h10);
        bb.out_ready = 1;
        #1;
        chk("bp_rel_ready", bb.in_ready, 1'b1);
        tick();
        chk("bp_out_11", bb.out_data, 8'h11);
        bb.in_valid = 0;
        tick();
        chk("bp_out_12_valid", bb.out_valid, 1'b1);
        chk("bp_out_12",       bb.out_data,  8'h12);
        tick();
        chk("bp_empty_valid", bb.out_valid, 1'b0);
        chk("bp_empty_busy",  busy_b,       1'b0);

        // Combinational bypass, DEPTH 0
        bz.in_valid = 1; bz.in_data = 8'h5A; bz.out_ready = 1;
        #1;
        chk("byp_valid", bz.out_valid, 1'b1);
        chk("byp_data",  bz.out_data,  8'h5A);
        chk("byp_ovf",   bz.out_ovf,   1'b0);
        chk("byp_ready", bz.in_ready,  1'b1);
        chk("byp_busy",  busy_z,       1'b0);
        bz.in_data = 8'hA5; bz.out_ready = 0;
        #1;
        chk("byp_data2",    bz.out_data, 8'hA5);
        chk("byp_ready_lo", bz.in_ready, 1'b0);
        bz.in_valid = 0;
        #1;
        chk("byp_valid_lo", bz.out_valid, 1'b0);

`ifdef GEN_IF_PIPE_STATS_EN
        rst_n = 0;
        #1;
        chk("st_rst_xfer",  xc[2], 4'h0);
        chk("st_rst_stall", sc[2], 4'h0);
        tick();
        rst_n = 1;
        tick();
        bb.out_ready = 1; bb.in_valid = 1;
        for (int i = 0; i < 20; i++) begin
            bb.in_data = 8'(i);
            tick();
        end
        bb.in_valid = 0;
        chk("st_xfer_sat", xc[2], 4'hF);
        tick(); tick();
        chk("st_stall_zero", sc[2], 4'h0);
        bb.out_ready = 0; bb.in_valid = 1; bb.in_data = 8'h77;
        tick();
        bb.in_valid = 0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("st_stall_5",    sc[2],       4'h5);
        chk("st_stall_data", bb.out_data, 8'h77);
        bb.out_ready = 1;
        tick();
        chk("st_stall_end",  sc[2],        4'h5);
        chk("st_drained",    bb.out_valid, 1'b0);
`endif

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares != 0)
            $error("FAIL summary: %0d miscompares", miscompares);
        else
            $display("PASS");
        $finish;
    end

endmodule

// File: doc/gen_if_pipe.md
Name: gen_if_pipe

Overview:
- Parametrised successor to the single-bit generate-if pass/increment block.
- Generalises data width, transform mode and register depth, and replaces the free-running combinational path with a valid/ready pipeline.
- Sits between producer and consumer datapaths in modules that need an optional increment stage with optional retiming.
- Build-time structure (bypass vs. registered chain, transform kind) is chosen entirely by generate-if on parameters.

Parameters:
- W, 8, data width in bits (>=1).
- DEPTH, 1, number of register slices (0 = purely combinational bypass; 0..8 legal).
- MODE, 0, transform: 0 = pass-through, 1 = +1 with wrap, 2 = +1 saturating.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer data valid.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  W  producer data.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  W  transformed data.
- out_ovf  output  1  overflow/saturation flag accompanying out_data.
- busy  output  1  at least one slice holds valid data.
- xfer_cnt  output  CNT_W  accepted input transfers (GEN_IF_PIPE_STATS_EN only).
- stall_cnt  output  CNT_W  cycles with out_valid && !out_ready (GEN_IF_PIPE_STATS_EN only).

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Transfer rule: a transfer occurs on a side when valid && ready are both high at the clock edge.
- Transform: applied combinationally to in_data before slice 0, or directly to out_data when DEPTH=0. The ovf bit is computed with the data and travels with it.
  - MODE 0: data unchanged, ovf=0.
  - MODE 1: data = in_data + 1, truncated to W bits. ovf=1 only when in_data is all ones, giving result 0.
  - MODE 2: data = in_data + 1, except all-ones stays all-ones. ovf=1 only when in_data is all ones.
- DEPTH=0: out_valid=in_valid, in_ready=out_ready, out_data/out_ovf are combinational from in_data. busy=0. No state.
- DEPTH>=1: chain of slices s[0..DEPTH-1], each holding {valid, data, ovf}.
  - ready[i] = !valid[i] || ready[i+1], where ready[DEPTH] = out_ready. in_ready = ready[0].
  - When ready[i] is high, the slice loads from its upstream: valid[i] <= upstream valid; data/ovf load only when upstream valid is high.
  - When ready[i] is low, the slice holds its contents.
- Latency and throughput: DEPTH cycles from input transfer to out_valid. Full throughput of one word per cycle under continuous out_ready=1.
- Outputs: out_valid=valid[DEPTH-1], out_data/out_ovf from the last slice. busy = OR of all valid[i].
- Backpressure: out_ready=0 with the pipeline full gives in_ready=0. out_data and out_ovf stay stable while out_valid && !out_ready.
- Simultaneous push/pop on a full pipeline: allowed through the ready chain; no bubble inserted.
- Reset (including mid-operation): all valid[i]=0, data=0, ovf=0. Hence out_valid=0, out_data=0, out_ovf=0, busy=0, in_ready=1 (DEPTH>=1). In-flight data is discarded.
- Illegal parameters (MODE>2, DEPTH>8, W<1): rejected by a generate-else branch calling $error at elaboration.

Optional Feature:
- Macro: GEN_IF_PIPE_STATS_EN.
- Defined:
  - xfer_cnt increments on every input transfer.
  - stall_cnt increments on every cycle with out_valid && !out_ready.
  - Both counters saturate at all ones and reset to 0.
- Undefined: the xfer_cnt/stall_cnt ports and logic are absent.

Decomposition:
- Package gen_if_pkg holds:
  - mode encoding constants MODE_PASS=0, MODE_INC=1, MODE_SAT=2;
  - DEPTH_MAX=8;
  - a function inc_xform(data, mode) returning {ovf, data}.
- Sub-module gen_if_slice: one {valid, data, ovf} register with the ready rule, instantiated DEPTH times in a generate-for inside the DEPTH>=1 generate-if branch.

Test Plan:
- Reset mid-stream: W=8, DEPTH=3, MODE=1, send 3 words, assert rst_n low for 1 cycle -> out_valid=0, busy=0, in_ready=1 immediately; no old words appear afterwards.
- Wrap: MODE=1, in_data=8'hFF -> out_data=8'h00, out_ovf=1, exactly 3 cycles later; in_data=8'h41 -> 8'h42, ovf=0.
- Saturation: MODE=2, in_data=8'hFF -> out_data=8'hFF, ovf=1; 8'hFE -> 8'hFF, ovf=0.
- Backpressure: DEPTH=2, out_ready=0, stream 0x10,0x11,0x12 -> two words accepted, then in_ready=0 and out_data holds 0x10; release out_ready -> outputs 0x10,0x11,0x12 in order, none lost or duplicated.
- Bypass: DEPTH=0, MODE=0 -> out_data==in_data and out_valid==in_valid in the same cycle; in_ready follows out_ready.
- Stats (GEN_IF_PIPE_STATS_EN, CNT_W=4): 20 transfers -> xfer_cnt=4'hF (saturated); 5 stalled cycles -> stall_cnt=5.
